// File: rtl/alu_instr_sequencer_pkg.sv
// Shared definitions for the ALU instruction sequencer: instruction field layout,
// opcode values, FSM state encoding and a field-extraction helper.
package alu_instr_sequencer_pkg;

  localparam int unsigned INSTR_W = 16;

  // Instruction word field positions
  localparam int unsigned HALT_BIT = 15;
  localparam int unsigned OP_MSB   = 14;
  localparam int unsigned OP_LSB   = 12;
  localparam int unsigned RD_MSB   = 11;
  localparam int unsigned RD_LSB   = 8;
  localparam int unsigned RT_MSB   = 7;
  localparam int unsigned RT_LSB   = 4;
  localparam int unsigned RS_MSB   = 3;
  localparam int unsigned RS_LSB   = 0;

  // ALU opcodes
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  // Sequencer FSM state encoding
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] ISSUE  = 3'd2;
  localparam logic [2:0] SETTLE = 3'd3;
  localparam logic [2:0] HALT   = 3'd4;

  typedef struct packed {
    logic       halt;
    logic [2:0] op;
    logic [3:0] rd;
    logic [3:0] rt;
    logic [3:0] rs;
  } instr_t;

  function automatic instr_t decode_instr(input logic [INSTR_W-1:0] w);
    instr_t d;
    d.halt = w[HALT_BIT];
    d.op   = w[OP_MSB:OP_LSB];
    d.rd   = w[RD_MSB:RD_LSB];
    d.rt   = w[RT_MSB:RT_LSB];
    d.rs   = w[RS_MSB:RS_LSB];
    return d;
  endfunction

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Instruction input handshake plus decoded issue outputs of the ALU sequencer.
// master: the instruction source / register bank side; slave: the sequencer.
interface alu_instr_sequencer_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic [15:0]      instr_in;
  logic             instr_valid;
  logic             instr_ready;
  logic [2:0]       ALU_Operation;
  logic [3:0]       Rd;
  logic [3:0]       Rt;
  logic [3:0]       Rs;
  logic             execute;
  logic             busy;
  logic             halted;
  logic [CNT_W-1:0] retired_count;

  modport master (
    output instr_in, instr_valid,
    input  instr_ready, ALU_Operation, Rd, Rt, Rs, execute, busy, halted, retired_count
  );

  modport slave (
    input  instr_in, instr_valid,
    output instr_ready, ALU_Operation, Rd, Rt, Rs, execute, busy, halted, retired_count
  );
endinterface

// File: rtl/alu_instr_sequencer_seq_fifo.sv
// Parameterised synchronous FIFO with full/empty/occupancy outputs.
// Push while full is honoured only when a pop frees the slot in the same cycle;
// a word pushed into an empty FIFO is readable from the following cycle.
module seq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage array, written without reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end
endmodule

// File: rtl/alu_instr_sequencer.sv
// ALU instruction sequencer: buffers instruction words, decodes them and issues one
// execute strobe per word, with SETTLE_CYCLES idle cycles after each strobe.
// A HALT word stops issue until reset.
// Optional ALU_SEQ_STEP_EN: adds a raw 'step' button input; each synchronised rising
// edge releases one instruction from IDLE.
module alu_instr_sequencer
  import alu_instr_sequencer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef ALU_SEQ_STEP_EN
  input  logic                 step,
`endif
  alu_instr_sequencer_if.slave bus
);
  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]         state_q, state_d;
  instr_t             instr_q, instr_d;
  logic [SW-1:0]      settle_q, settle_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               pop, go;
  logic               fifo_full, fifo_empty;
  logic [INSTR_W-1:0] fifo_rdata;
  logic [CW-1:0]      fifo_count;
  logic               halted;

  assign halted = (state_q == HALT);

  seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.instr_valid && bus.instr_ready),
    .pop   (pop),
    .wdata (bus.instr_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef ALU_SEQ_STEP_EN
  logic step_s1_q, step_s2_q, step_s3_q;

  // Two-flop synchroniser plus one delay flop for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      step_s1_q <= 1'b0;
      step_s2_q <= 1'b0;
      step_s3_q <= 1'b0;
    end else begin
      step_s1_q <= step;
      step_s2_q <= step_s1_q;
      step_s3_q <= step_s2_q;
    end
  end

  assign go = step_s2_q && !step_s3_q;
`else
  assign go = 1'b1;
`endif

  // Next-state logic: pop in IDLE, branch on HALT in DECODE, strobe, then settle
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    settle_d  = settle_q;
    retired_d = retired_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && go) begin
          pop     = 1'b1;
          instr_d = decode_instr(fifo_rdata);
          state_d = DECODE;
        end
      end
      DECODE: state_d = instr_q.halt ? HALT : ISSUE;
      ISSUE: begin
        retired_d = retired_q + 1'b1;
        settle_d  = SW'(SETTLE_CYCLES);
        state_d   = SETTLE;
      end
      SETTLE: begin
        settle_d = settle_q - 1'b1;
        if (settle_q == SW'(1)) state_d = IDLE;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any in-flight issue
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      settle_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      settle_q  <= settle_d;
      retired_q <= retired_d;
    end
  end

  // Decoded fields come straight from the decode register so they hold until the next pop
  assign bus.ALU_Operation = instr_q.op;
  assign bus.Rd            = instr_q.rd;
  assign bus.Rt            = instr_q.rt;
  assign bus.Rs            = instr_q.rs;
  assign bus.execute       = (state_q == ISSUE);
  assign bus.halted        = halted;
  assign bus.busy          = (state_q != IDLE) || (fifo_count != '0);
  assign bus.instr_ready   = !fifo_full && !halted;
  assign bus.retired_count = retired_q;
endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Self-checking bench for alu_instr_sequencer: a schedule-level model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_alu_instr_sequencer;
  localparam int unsigned D  = 4;
  localparam int unsigned S  = 2;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_instr_sequencer_if #(.CNT_W(CW)) bus ();
`ifdef ALU_SEQ_STEP_EN
  logic step = 1'b0;
`endif

  alu_instr_sequencer #(
    .FIFO_DEPTH    (D),
    .SETTLE_CYCLES (S),
    .CNT_W         (CW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef ALU_SEQ_STEP_EN
    .step (step),
`endif
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int exec_log[$];
  logic [3:0] exec_rd[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Words queue up; a pop happens whenever the sequencer is free and a word is waiting.
  // A normal word strobes execute one cycle after its pop and blocks the next pop for
  // 3+S cycles in total; a HALT word freezes everything one cycle after its pop.
  logic [15:0] mq[$];
  int          m_gap = 0;
  bit          m_stop = 0, m_halted = 0, m_exec = 0, m_ready = 0;
  int          m_exec_in = 0, m_halt_in = 0;
  logic [15:0] m_fields = '0;
  logic [CW-1:0] m_cnt = '0;
  logic [2:0]  m_step_h = '0;

  always @(posedge clk) begin : model
    bit accept, go;
    logic [15:0] w;
    cyc++;
    if (rst) begin
      mq.delete();
      m_gap = 0; m_stop = 0; m_halted = 0; m_exec = 0;
      m_exec_in = 0; m_halt_in = 0; m_fields = '0; m_cnt = '0; m_step_h = '0;
    end else begin
      accept = bus.instr_valid && m_ready;
      if (m_exec) m_cnt++;
      m_exec = 0;
      if (m_exec_in > 0) begin m_exec_in--; if (m_exec_in == 0) m_exec = 1; end
      if (m_halt_in > 0) begin m_halt_in--; if (m_halt_in == 0) m_halted = 1; end
      go = 1'b1;
`ifdef ALU_SEQ_STEP_EN
      go = m_step_h[1] && !m_step_h[2];
      m_step_h = {m_step_h[1:0], step};
`endif
      if (m_gap > 0) m_gap--;
      else if (!m_stop && mq.size() > 0 && go) begin
        w = mq.pop_front();
        m_fields = w;
        if (w[15]) begin m_stop = 1; m_halt_in = 1; end
        else begin m_exec_in = 1; m_gap = 2 + S; end
      end
      if (accept) mq.push_back(bus.instr_in);
    end
    m_ready = (mq.size() < D) && !m_halted;
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cyc >= 1) begin
      check("execute", {31'b0, bus.execute}, {31'b0, m_exec});
      check("instr_ready", {31'b0, bus.instr_ready}, {31'b0, m_ready});
      check("busy", {31'b0, bus.busy}, {31'b0, (m_gap > 0) || m_stop || (mq.size() > 0)});
      check("halted", {31'b0, bus.halted}, {31'b0, m_halted});
      check("ALU_Operation", {29'b0, bus.ALU_Operation}, {29'b0, m_fields[14:12]});
      check("Rd", {28'b0, bus.Rd}, {28'b0, m_fields[11:8]});
      check("Rt", {28'b0, bus.Rt}, {28'b0, m_fields[7:4]});
      check("Rs", {28'b0, bus.Rs}, {28'b0, m_fields[3:0]});
      check("retired_count", {16'b0, bus.retired_count}, {16'b0, m_cnt});
      if (bus.execute) begin
        exec_log.push_back(cyc);
        exec_rd.push_back(bus.Rd);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [15:0] w);
    int g;
    g = 0;
    bus.instr_in = w;
    bus.instr_valid = 1'b1;
    while (!bus.instr_ready && g < 100) begin tick(); g++; end
    if (g >= 100) check("push_timeout", 32'd0, 32'd1);
    tick();
    bus.instr_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_exec(input int budget, output int at);
    int g;
    g = 0;
    at = -1;
    while (!bus.execute && g < budget) begin tick(); g++; end
    if (bus.execute) at = cyc;
    else check("exec_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : stim
    int a, at, base, idx, guard;
    bit rdy;
    logic [15:0] w [6];
    bus.instr_in = '0;
    bus.instr_valid = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_ready", {31'b0, bus.instr_ready}, 32'd1);
    check("rst_count", {16'b0, bus.retired_count}, 32'd0);
    check("rst_halted", {31'b0, bus.halted}, 32'd0);

`ifndef ALU_SEQ_STEP_EN
    // Single sub instruction
    push(16'h1321);
    a = cyc;
    wait_exec(10, at);
    check("exec_latency", at - a, 32'd2);
    check("sub_op", {29'b0, bus.ALU_Operation}, 32'h1);
    check("sub_rd", {28'b0, bus.Rd}, 32'h3);
    check("sub_rt", {28'b0, bus.Rt}, 32'h2);
    check("sub_rs", {28'b0, bus.Rs}, 32'h1);
    tick();
    check("sub_retired", {16'b0, bus.retired_count}, 32'd1);

    // Six back-to-back words through a 4-deep FIFO
    for (int i = 0; i < 6; i++) w[i] = {1'b0, 3'(i), 4'(i + 4), 4'(i + 8), 4'(15 - i)};
    base = exec_log.size();
    idx = 0;
    guard = 0;
    while (idx < 6 && guard < 200) begin
      bus.instr_in = w[idx];
      bus.instr_valid = 1'b1;
      rdy = bus.instr_ready;
      tick();
      if (rdy) idx++;
      guard++;
    end
    bus.instr_valid = 1'b0;
    check("burst_accepts", idx, 32'd6);
    guard = 0;
    while (exec_log.size() < base + 6 && guard < 100) begin tick(); guard++; end
    check("burst_issued", exec_log.size() - base, 32'd6);
    if (exec_log.size() >= base + 6) begin
      for (int k = 0; k < 6; k++) check("burst_order_rd", {28'b0, exec_rd[base + k]}, k + 4);
      for (int k = 1; k < 6; k++)
        check("burst_spacing", exec_log[base + k] - exec_log[base + k - 1], 3 + S);
    end
    repeat (10) tick();
    check("burst_retired", {16'b0, bus.retired_count}, 32'd7);

    // add, HALT, xor: only the add issues
    reset_pulse();
    base = exec_log.size();
    push(16'h0123);
    push(16'h8000);
    push(16'h4456);
    repeat (30) tick();
    check("halt_halted", {31'b0, bus.halted}, 32'd1);
    check("halt_ready", {31'b0, bus.instr_ready}, 32'd0);
    check("halt_retired", {16'b0, bus.retired_count}, 32'd1);
    check("halt_exec_count", exec_log.size() - base, 32'd1);
    check("halt_busy", {31'b0, bus.busy}, 32'd1);
    reset_pulse();
    check("halt_cleared", {31'b0, bus.halted}, 32'd0);
    check("halt_ready_back", {31'b0, bus.instr_ready}, 32'd1);

    // Reset during SETTLE with words still queued
    push(16'h0111);
    push(16'h0222);
    push(16'h0333);
    push(16'h0444);
    wait_exec(20, at);
    repeat (2) tick();
    reset_pulse();
    check("midrst_busy", {31'b0, bus.busy}, 32'd0);
    check("midrst_ready", {31'b0, bus.instr_ready}, 32'd1);
    check("midrst_count", {16'b0, bus.retired_count}, 32'd0);
    base = exec_log.size();
    repeat (10) tick();
    check("midrst_no_exec", exec_log.size() - base, 32'd0);
`else
    // Step mode: three queued words, two presses, then one long press
    base = exec_log.size();
    push(16'h0111);
    push(16'h0222);
    push(16'h0333);
    repeat (10) tick();
    check("step_none", exec_log.size() - base, 32'd0);
    step = 1'b1; repeat (3) tick(); step = 1'b0; repeat (10) tick();
    step = 1'b1; repeat (3) tick(); step = 1'b0; repeat (10) tick();
    check("step_two", exec_log.size() - base, 32'd2);
    check("step_retired", {16'b0, bus.retired_count}, 32'd2);
    step = 1'b1; repeat (20) tick(); step = 1'b0; repeat (10) tick();
    check("step_hold", exec_log.size() - base, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
endmodule
